// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one AXI4-Stream UART transmitter.
// Optional stalled-owner eviction is enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  input  logic [PORTS-1:0]            input_axis_tlast,
  output logic [PORTS-1:0]            input_axis_tready,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic [$clog2(PORTS)-1:0]    grant,
  output logic                        grant_valid,
  output logic                        timeout
);

  localparam int unsigned GW = $clog2(PORTS);

  if (PORTS < 2 || PORTS > 8) begin : g_bad_ports
    $error("uart_tx_arbiter: PORTS must be 2..8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65536) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must be 2..65536");
  end

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [GW-1:0] grant_next;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] last_next;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic          found;
  logic          any_req;
  logic          own_valid;
  logic          own_last;
  logic          beat;

  assign any_req = |input_axis_tvalid;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      cand = GW'((32'(last_grant) + i) % PORTS);
      if (!found && input_axis_tvalid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Select the current owner's stream signals.
  always_comb begin
    own_valid         = 1'b0;
    own_last          = 1'b0;
    output_axis_tdata = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (grant == GW'(i)) begin
        own_valid         = input_axis_tvalid[i];
        own_last          = input_axis_tlast[i];
        output_axis_tdata = input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pass-through handshake; only the owner ever sees tready.
  always_comb begin
    output_axis_tvalid = 1'b0;
    input_axis_tready  = '0;
    if (state == S_GRANT) begin
      output_axis_tvalid = own_valid;
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (grant == GW'(i)) begin
          input_axis_tready[i] = output_axis_tready;
        end
      end
    end
  end

  assign beat = (state == S_GRANT) && own_valid && output_axis_tready;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  logic [15:0] idle_cnt;
  logic [15:0] idle_cnt_next;
  logic        timeout_next;
`endif

  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last_grant;
`ifdef ARB_TIMEOUT_EN
    idle_cnt_next = idle_cnt;
    timeout_next  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_next = S_GRANT;
          grant_next = winner;
`ifdef ARB_TIMEOUT_EN
          idle_cnt_next = '0;
`endif
        end
      end
      S_GRANT: begin
        if (beat && own_last) begin
          state_next = S_IDLE;
          last_next  = grant;
        end
`ifdef ARB_TIMEOUT_EN
        // Evict an owner that has offered nothing for TIMEOUT cycles.
        if (beat) begin
          idle_cnt_next = '0;
        end else if (!own_valid) begin
          if (idle_cnt == IDLE_LAST) begin
            state_next    = S_IDLE;
            last_next     = grant;
            timeout_next  = 1'b1;
            idle_cnt_next = '0;
          end else begin
            idle_cnt_next = idle_cnt + 16'd1;
          end
        end
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      last_grant  <= GW'(PORTS - 1);
`ifdef ARB_TIMEOUT_EN
      idle_cnt    <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      grant_valid <= (state_next == S_GRANT);
      last_grant  <= last_next;
`ifdef ARB_TIMEOUT_EN
      idle_cnt    <= idle_cnt_next;
      timeout     <= timeout_next;
`endif
    end
  end

`ifndef ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (4 ports, 8-bit data, TIMEOUT=16).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] input_axis_tdata;
  logic [3:0]  input_axis_tvalid;
  logic [3:0]  input_axis_tlast;
  logic [3:0]  input_axis_tready;
  logic [7:0]  output_axis_tdata;
  logic        output_axis_tvalid;
  logic        output_axis_tready;
  logic [1:0]  grant;
  logic        grant_valid;
  logic        timeout;

  int tests  = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .PORTS      (4),
    .DATA_WIDTH (8),
    .TIMEOUT    (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (input_axis_tdata),
    .input_axis_tvalid  (input_axis_tvalid),
    .input_axis_tlast   (input_axis_tlast),
    .input_axis_tready  (input_axis_tready),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .grant              (grant),
    .grant_valid        (grant_valid),
    .timeout            (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  tv;
    logic [3:0]  tl;
    logic [31:0] td;
    logic        ordy;
    logic        ov;
    logic [7:0]  od;
    logic [3:0]  tr;
    logic [1:0]  g;
    logic        gv;
    logic        to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic r, input logic [3:0] tv, input logic [3:0] tl,
                               input logic [31:0] td, input logic ordy, input logic ov,
                               input logic [7:0] od, input logic [3:0] tr, input logic [1:0] g,
                               input logic gv);
    vec_t v;
    v.rst = r;  v.tv = tv; v.tl = tl; v.td = td; v.ordy = ordy;
    v.ov  = ov; v.od = od; v.tr = tr; v.g  = g;  v.gv = gv; v.to = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] tv, input logic [3:0] tl,
                       input logic [31:0] td, input logic ordy);
    rst                = r;
    input_axis_tvalid  = tv;
    input_axis_tlast   = tl;
    input_axis_tdata   = td;
    output_axis_tready = ordy;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state; tvalid asserted during reset must not produce tready.
    vecs.push_back(mkv(0, 4'hF, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 0, 0));
    vecs.push_back(mkv(0, 4'hF, 4'hF, 32'h0,        1, 0, 8'h00, 4'h0, 0, 0));
    // Port 1 three-byte message.
    vecs.push_back(mkv(1, 4'h2, 4'h0, 32'h00004100, 1, 0, 8'h00, 4'h0, 0, 0));
    vecs.push_back(mkv(1, 4'h2, 4'h0, 32'h00004100, 1, 1, 8'h41, 4'h2, 1, 1));
    vecs.push_back(mkv(1, 4'h2, 4'h0, 32'h00004200, 1, 1, 8'h42, 4'h2, 1, 1));
    vecs.push_back(mkv(1, 4'h2, 4'h2, 32'h00004300, 1, 1, 8'h43, 4'h2, 1, 1));
    vecs.push_back(mkv(1, 4'h0, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 1, 0));
    // Reset, then all ports stream one-byte messages: 0,1,2,3,0 with bubbles.
    vecs.push_back(mkv(0, 4'h0, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 1, 0));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 4'h0, 0, 0));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 32'h13121110, 1, 1, 8'h10, 4'h1, 0, 1));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 4'h0, 0, 0));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 32'h13121110, 1, 1, 8'h11, 4'h2, 1, 1));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 4'h0, 1, 0));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 32'h13121110, 1, 1, 8'h12, 4'h4, 2, 1));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 4'h0, 2, 0));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 32'h13121110, 1, 1, 8'h13, 4'h8, 3, 1));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 32'h13121110, 1, 0, 8'h00, 4'h0, 3, 0));
    vecs.push_back(mkv(1, 4'hF, 4'hF, 32'h13121110, 1, 1, 8'h10, 4'h1, 0, 1));
    // Port 2 owns while port 0 waits; uart tready toggles; owner briefly drops tvalid.
    vecs.push_back(mkv(1, 4'h4, 4'h0, 32'h002A0055, 1, 0, 8'h00, 4'h0, 0, 0));
    vecs.push_back(mkv(1, 4'h5, 4'h0, 32'h002A0055, 0, 1, 8'h2A, 4'h0, 2, 1));
    vecs.push_back(mkv(1, 4'h5, 4'h0, 32'h002A0055, 1, 1, 8'h2A, 4'h4, 2, 1));
    vecs.push_back(mkv(1, 4'h1, 4'h0, 32'h002B0055, 1, 0, 8'h00, 4'h4, 2, 1));
    vecs.push_back(mkv(1, 4'h5, 4'h0, 32'h002B0055, 0, 1, 8'h2B, 4'h0, 2, 1));
    vecs.push_back(mkv(1, 4'h5, 4'h0, 32'h002B0055, 1, 1, 8'h2B, 4'h4, 2, 1));
    vecs.push_back(mkv(1, 4'h5, 4'h4, 32'h002C0055, 0, 1, 8'h2C, 4'h0, 2, 1));
    vecs.push_back(mkv(1, 4'h5, 4'h4, 32'h002C0055, 1, 1, 8'h2C, 4'h4, 2, 1));
    vecs.push_back(mkv(1, 4'h1, 4'h1, 32'h00000055, 1, 0, 8'h00, 4'h0, 2, 0));
    vecs.push_back(mkv(1, 4'h1, 4'h1, 32'h00000055, 1, 1, 8'h55, 4'h1, 0, 1));
    vecs.push_back(mkv(1, 4'h0, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 0, 0));
    // Reset after one of three bytes; port 0 wins afterwards even though port 1 still requests.
    vecs.push_back(mkv(1, 4'h2, 4'h0, 32'h00006100, 1, 0, 8'h00, 4'h0, 0, 0));
    vecs.push_back(mkv(1, 4'h2, 4'h0, 32'h00006100, 1, 1, 8'h61, 4'h2, 1, 1));
    vecs.push_back(mkv(0, 4'h2, 4'h0, 32'h00006200, 0, 1, 8'h62, 4'h0, 1, 1));
    vecs.push_back(mkv(1, 4'h3, 4'h1, 32'h00006270, 1, 0, 8'h00, 4'h0, 0, 0));
    vecs.push_back(mkv(1, 4'h3, 4'h1, 32'h00006270, 1, 1, 8'h70, 4'h1, 0, 1));
    vecs.push_back(mkv(1, 4'h0, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 0, 0));

    drive(0, 4'h0, 4'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].rst, vecs[n].tv, vecs[n].tl, vecs[n].td, vecs[n].ordy);
      #1;
      check($sformatf("v%0d.tvalid", n), 32'(output_axis_tvalid), 32'(vecs[n].ov));
      if (vecs[n].ov)
        check($sformatf("v%0d.tdata", n), 32'(output_axis_tdata), 32'(vecs[n].od));
      check($sformatf("v%0d.tready", n), 32'(input_axis_tready), 32'(vecs[n].tr));
      check($sformatf("v%0d.grant", n), 32'(grant), 32'(vecs[n].g));
      check($sformatf("v%0d.grant_valid", n), 32'(grant_valid), 32'(vecs[n].gv));
      check($sformatf("v%0d.timeout", n), 32'(timeout), 32'(vecs[n].to));
    end

    // Port 3 sends one byte without tlast, then stalls while port 0 waits.
    @(negedge clk);
    drive(1, 4'h8, 4'h0, 32'h77000000, 1'b1);
    #1;
    check("stall.idle_gv", 32'(grant_valid), 32'd0);
    @(negedge clk);
    #1;
    check("stall.grant", 32'(grant), 32'd3);
    check("stall.tdata", 32'(output_axis_tdata), 32'h77);
    check("stall.tready", 32'(input_axis_tready), 32'h8);
    @(negedge clk);
    drive(1, 4'h1, 4'h1, 32'h00000055, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("idle%0d.timeout", k), 32'(timeout), 32'd0);
      check($sformatf("idle%0d.grant", k), 32'(grant), 32'd3);
      check($sformatf("idle%0d.gv", k), 32'(grant_valid), 32'd1);
    end
    @(negedge clk);
    #1;
    check("evict.timeout", 32'(timeout), 32'd1);
    check("evict.gv", 32'(grant_valid), 32'd0);
    check("evict.tready", 32'(input_axis_tready), 32'h0);
    @(negedge clk);
    #1;
    check("after.timeout", 32'(timeout), 32'd0);
    check("after.grant", 32'(grant), 32'd0);
    check("after.gv", 32'(grant_valid), 32'd1);
    check("after.tdata", 32'(output_axis_tdata), 32'h55);
    check("after.tready", 32'(input_axis_tready), 32'h1);
`else
    for (int k = 0; k < 2000; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("hold%0d.grant", k), 32'(grant), 32'd3);
      check($sformatf("hold%0d.gv", k), 32'(grant_valid), 32'd1);
      check($sformatf("hold%0d.timeout", k), 32'(timeout), 32'd0);
      check($sformatf("hold%0d.tready", k), 32'(input_axis_tready), 32'h8);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
